// File: rtl/dm_access_master.sv
// dm_access_master
//   Initiator for the data-memory port. Takes one load/store at a time from the
//   MEM stage, drives the data memory (registered-read responder), waits out its
//   latency and returns a one-cycle completion pulse. Out-of-range or misaligned
//   requests are rejected without touching the memory.
//
// Ports
//   clk, rst                  clock (rising edge) / asynchronous active-high reset
//   req_valid/req_we/req_addr/req_wdata   request from the pipeline
//   req_ready                 high only in IDLE; the pipeline stalls while low
//   resp_valid/resp_rdata/resp_err/resp_ram2   completion (one-cycle pulse)
//   busy                      state != IDLE
//   mem_addr/mem_wdata/mem_read/mem_write  toward the data memory
//   mem_rdata/mem_src         from the data memory
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready are
// both high. The request is latched at that edge, so req_valid/req_addr may change
// freely afterwards. resp_valid is a single-cycle pulse with no back-pressure;
// resp_err, resp_rdata and resp_ram2 are meaningful while resp_valid is high.
//
// Timing (W = WAIT_CYCLES): legal access IDLE -> ISSUE -> WAIT x W -> CAPTURE ->
// RESP, so resp_valid comes 3+W cycles after the accepting cycle; a rejected
// request goes IDLE -> RESP (1 cycle).
module dm_access_master #(
  parameter int WAIT_CYCLES = 0,
  parameter int MEM_WORDS   = 255,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_ram2,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata,
  input  logic        mem_src
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [15:0] WORDS_LIM = 16'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ram2_q, ram2_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        busy_q, busy_d;
  logic        req_illegal;
  logic        accept;

  always_comb begin
    req_illegal = ({2'b00, req_addr[15:2]} >= WORDS_LIM) ||
                  ((ALIGN_CHECK != 1'b0) && (req_addr[1:0] != 2'b00));
    accept      = req_valid && req_ready_q;

    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram2_d  = ram2_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          if (req_illegal) begin
            err_d   = 1'b1;
            ram2_d  = 1'b0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = WAIT_LOAD;
        state_d = (WAIT_LOAD != 4'd0) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        // Counter was loaded with WAIT_CYCLES; leaving at 1 gives exactly
        // WAIT_CYCLES cycles in this state. <= also covers a stray 0.
        if (cnt_q <= 4'd1) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        // Stores leave the last load data untouched.
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
        ram2_d  = mem_src;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so every strobe is a clean flop.
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    mem_read_d   = (state_d == S_ISSUE) && !we_d;
    mem_write_d  = (state_d == S_ISSUE) && we_d;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      rdata_q      <= 16'h0000;
      err_q        <= 1'b0;
      ram2_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      ram2_q       <= ram2_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
    end
  end

  // Address and data come straight from the latched request, so they are
  // stable from ISSUE through CAPTURE.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign resp_ram2  = ram2_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dm_access_master.sv
// Bench for dm_access_master: instance 0 with WAIT_CYCLES=0, instance 1 with
// WAIT_CYCLES=3, each attached to its own registered-read memory. A behavioural
// model predicts ready/busy, strobe cycles and response contents from the
// accept cycle and the access rules; one checker compares every cycle.
module tb_dm_access_master;

  typedef struct {
    int          due;
    int          k;
    logic [15:0] rdata;
    logic        err;
    logic        ram2;
  } resp_t;

  typedef struct {
    int          due;
    int          k;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } stb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        resp_ram2  [2];
  logic        busy       [2];
  logic [15:0] mem_addr   [2];
  logic [15:0] mem_wdata  [2];
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [15:0] mem_rdata  [2];
  logic        mem_src    [2];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // model state
  resp_t       exp_q [$];
  stb_t        stb_q [$];
  int          ready_from [2];
  logic [15:0] shadow     [2][256];
  logic [15:0] last_rdata [2];
  int          stab_from  [2];
  int          stab_to    [2];
  logic [15:0] stab_addr  [2];
  int          rd_pulses  [2];
  int          wr_pulses  [2];

  function automatic logic [15:0] init_word(input int i);
    if (i == 2) return 16'h1234;
    return 16'((i * 37) + 16'h0100);
  endfunction

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [15:0] ram [256];
    logic [15:0] rd_reg;
    logic        src_reg;

    initial begin
      for (int i = 0; i < 256; i++) ram[i] = init_word(i);
      rd_reg  = 16'h0000;
      src_reg = 1'b0;
    end

    always @(posedge clk) begin
      if (mem_write[g]) ram[mem_addr[g][9:2]] <= mem_wdata[g];
      if (mem_read[g]) rd_reg <= ram[mem_addr[g][9:2]];
      if (mem_read[g] || mem_write[g]) src_reg <= mem_addr[g][2] ^ mem_addr[g][3];
    end

    assign mem_rdata[g] = rd_reg;
    assign mem_src[g]   = src_reg;

    dm_access_master #(
      .WAIT_CYCLES((g == 0) ? 0 : 3),
      .MEM_WORDS  (255),
      .ALIGN_CHECK(1'b1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .resp_ram2 (resp_ram2[g]),
      .busy      (busy[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .mem_rdata (mem_rdata[g]),
      .mem_src   (mem_src[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    bit    exp_ready, exp_rv, exp_rd, exp_wr, legal;
    int    lat, idx;
    resp_t e, ne;
    stb_t  s, ns;
    if (rst) begin
      exp_q.delete();
      stb_q.delete();
      for (int k = 0; k < 2; k++) begin
        ready_from[k] = 0;
        last_rdata[k] = 16'h0000;
        stab_from[k]  = 1;
        stab_to[k]    = 0;
        chk($sformatf("rst_ready%0d", k), req_ready[k], 1);
        chk($sformatf("rst_busy%0d", k), busy[k], 0);
        chk($sformatf("rst_resp_valid%0d", k), resp_valid[k], 0);
        chk($sformatf("rst_mem_read%0d", k), mem_read[k], 0);
        chk($sformatf("rst_mem_write%0d", k), mem_write[k], 0);
        chk($sformatf("rst_rdata%0d", k), resp_rdata[k], 0);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_read[k]) rd_pulses[k]++;
        if (mem_write[k]) wr_pulses[k]++;
        exp_ready = (cyc >= ready_from[k]);
        chk($sformatf("ready%0d", k), req_ready[k], exp_ready);
        chk($sformatf("busy%0d", k), busy[k], !exp_ready);

        exp_rv = 1'b0;
        e = '{due: 0, k: 0, rdata: 16'h0, err: 1'b0, ram2: 1'b0};
        foreach (exp_q[i]) if (exp_q[i].k == k && exp_q[i].due == cyc) begin
          exp_rv = 1'b1;
          e = exp_q[i];
        end
        chk($sformatf("resp_valid%0d", k), resp_valid[k], exp_rv);
        if (exp_rv) begin
          chk($sformatf("resp_err%0d", k), resp_err[k], e.err);
          chk($sformatf("resp_rdata%0d", k), resp_rdata[k], e.rdata);
          if (!e.err) chk($sformatf("resp_ram2%0d", k), resp_ram2[k], e.ram2);
        end

        exp_rd = 1'b0;
        exp_wr = 1'b0;
        s = '{due: 0, k: 0, we: 1'b0, addr: 16'h0, wdata: 16'h0};
        foreach (stb_q[i]) if (stb_q[i].k == k && stb_q[i].due == cyc) begin
          s = stb_q[i];
          exp_rd = !s.we;
          exp_wr = s.we;
        end
        chk($sformatf("mem_read%0d", k), mem_read[k], exp_rd);
        chk($sformatf("mem_write%0d", k), mem_write[k], exp_wr);
        if (exp_wr) chk($sformatf("mem_wdata%0d", k), mem_wdata[k], s.wdata);
        if (cyc >= stab_from[k] && cyc <= stab_to[k])
          chk($sformatf("mem_addr%0d", k), mem_addr[k], stab_addr[k]);

        // accept: predict the whole access from the request alone
        if (req_valid[k] && exp_ready) begin
          idx   = int'(req_addr[k] >> 2);
          legal = (idx < 255) && (req_addr[k][1:0] == 2'b00);
          lat   = legal ? (3 + ((k == 0) ? 0 : 3)) : 1;
          ready_from[k] = cyc + lat + 1;
          ne = '{due: cyc + lat, k: k, rdata: last_rdata[k], err: !legal,
                 ram2: req_addr[k][2] ^ req_addr[k][3]};
          if (legal) begin
            ns = '{due: cyc + 1, k: k, we: req_we[k], addr: req_addr[k], wdata: req_wdata[k]};
            stb_q.push_back(ns);
            stab_from[k] = cyc + 1;
            stab_to[k]   = cyc + lat - 1;
            stab_addr[k] = req_addr[k];
            if (req_we[k]) begin
              shadow[k][idx] = req_wdata[k];
            end else begin
              last_rdata[k] = shadow[k][idx];
              ne.rdata      = shadow[k][idx];
            end
          end
          exp_q.push_back(ne);
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].due <= cyc) exp_q.delete(i);
      for (int i = stb_q.size() - 1; i >= 0; i--) if (stb_q[i].due <= cyc) stb_q.delete(i);
    end
  end

  // driver tasks
  task automatic drive(input int k, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
  endtask

  task automatic wait_accept(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < 50);
    if (!req_ready[k]) chk($sformatf("accept_timeout%0d", k), 0, 1);
  endtask

  task automatic wait_resp(input int k, output int lat, output logic [15:0] rd, output logic err);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[k] && lat < 40);
    if (!resp_valid[k]) chk($sformatf("resp_timeout%0d", k), 0, 1);
    rd  = resp_rdata[k];
    err = resp_err[k];
  endtask

  task automatic issue(input int k, input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       output int lat, output logic [15:0] rd, output logic err);
    drive(k, we, addr, wd);
    wait_accept(k);
    @(posedge clk);
    #1;
    // request is latched; scramble the bus to show it is no longer looked at
    req_valid[k] = 1'b0;
    req_addr[k]  = 16'($urandom_range(0, 16'hFFFF));
    req_wdata[k] = 16'($urandom_range(0, 16'hFFFF));
    req_we[k]    = 1'($urandom_range(0, 1));
    wait_resp(k, lat, rd, err);
  endtask

  initial begin
    int          lat, n_low, rv_at, rd0, wr0;
    logic [15:0] rd;
    logic        err;
    logic [15:0] a;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 16'h0;
      req_wdata[k] = 16'h0;
      rd_pulses[k] = 0;
      wr_pulses[k] = 0;
      for (int i = 0; i < 256; i++) shadow[k][i] = init_word(i);
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready[0], 1);
    chk("reset_rdata", resp_rdata[1], 0);
    #2 rst = 1'b0;

    // 1: load 0x0008 with WAIT_CYCLES=0
    rd0 = rd_pulses[0];
    issue(0, 1'b0, 16'h0008, 16'h0, lat, rd, err);
    chk("t1_latency", lat, 3);
    chk("t1_rdata", rd, 16'h1234);
    chk("t1_err", err, 0);
    chk("t1_read_pulses", rd_pulses[0] - rd0, 1);

    // 2: store then load back
    wr0 = wr_pulses[0];
    issue(0, 1'b1, 16'h0010, 16'hBEEF, lat, rd, err);
    chk("t2_store_latency", lat, 3);
    chk("t2_store_rdata_held", rd, 16'h1234);
    chk("t2_store_err", err, 0);
    chk("t2_write_pulses", wr_pulses[0] - wr0, 1);
    issue(0, 1'b0, 16'h0010, 16'h0, lat, rd, err);
    chk("t2_load_rdata", rd, 16'hBEEF);

    // 3: rejected requests and the last legal word
    rd0 = rd_pulses[0];
    wr0 = wr_pulses[0];
    issue(0, 1'b0, 16'h03FC, 16'h0, lat, rd, err);
    chk("t3_idx255_latency", lat, 1);
    chk("t3_idx255_err", err, 1);
    issue(0, 1'b0, 16'h0006, 16'h0, lat, rd, err);
    chk("t3_misalign_latency", lat, 1);
    chk("t3_misalign_err", err, 1);
    issue(0, 1'b1, 16'hFFFC, 16'h5555, lat, rd, err);
    chk("t3_high_err", err, 1);
    chk("t3_no_strobes", (rd_pulses[0] - rd0) + (wr_pulses[0] - wr0), 0);
    issue(0, 1'b0, 16'h03F8, 16'h0, lat, rd, err);
    chk("t3_idx254_latency", lat, 3);
    chk("t3_idx254_err", err, 0);
    chk("t3_idx254_rdata", rd, init_word(254));

    // 4: WAIT_CYCLES=3, back-to-back loads with req_valid held
    drive(1, 1'b0, 16'h0020, 16'h0);
    wait_accept(1);
    @(posedge clk);
    #1 req_addr[1] = 16'h0024;
    n_low = 0;
    rv_at = -1;
    do begin
      @(negedge clk);
      if (resp_valid[1]) begin
        rv_at = n_low + 1;
        chk("t4_first_rdata", resp_rdata[1], init_word(8));
      end
      if (!req_ready[1]) n_low++;
    end while (!req_ready[1] && n_low < 40);
    chk("t4_ready_low", n_low, 6);
    chk("t4_first_latency", rv_at, 6);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_resp(1, lat, rd, err);
    chk("t4_second_latency", lat, 6);
    chk("t4_second_rdata", rd, init_word(9));

    // 5: reset while in WAIT
    drive(1, 1'b0, 16'h0030, 16'h0);
    wait_accept(1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy[1], 0);
    chk("t5_mem_read", mem_read[1], 0);
    chk("t5_resp_valid", resp_valid[1], 0);
    chk("t5_ready", req_ready[1], 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    issue(1, 1'b0, 16'h0008, 16'h0, lat, rd, err);
    chk("t5_after_latency", lat, 6);
    chk("t5_after_rdata", rd, 16'h1234);
    chk("t5_after_err", err, 0);

    // random traffic, checked by the model
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        case ($urandom_range(0, 9))
          6: a = 16'h03F8;
          7: a = 16'h03FC;
          8: a = 16'((($urandom_range(0, 15)) << 2) | $urandom_range(1, 3));
          9: a = 16'($urandom_range(0, 16'hFFFF));
          default: a = 16'($urandom_range(0, 15) << 2);
        endcase
        issue(k, 1'($urandom_range(0, 1)), a, 16'($urandom_range(0, 16'hFFFF)), lat, rd, err);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
